seq_detector_prog: RTL

- Runtime-programmable serial bit-pattern detector, generalising the fixed-pattern Mealy detectors in the Task1 sequence-detector set.
- Pattern, length and overlap mode are loaded through a config strobe.
- Produces a registered one-cycle detect pulse and a saturating match counter.
- Sits after a serial bit source with a qualifying valid strobe.

---
 rtl/seq_detector_prog.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial bit-pattern detector.
// A pattern, a length and an overlap mode are latched by cfg_load. Accepted
// bits shift into a history register, and a full-length match against the
// pattern produces a registered one-cycle seq_detected pulse and bumps a
// saturating match counter.
// Optional feature: define SEQ_DET_MASK_EN to add a cfg_mask port that marks
// individual pattern positions as don't-care.
module seq_detector_prog #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 LEN_W           = 4,
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0001_0101,
  parameter int                 DEFAULT_LEN     = 5,
  parameter bit                 DEFAULT_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill_level
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] cmp_mask;

  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               det_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;

`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] mask_q;
  assign cmp_mask = mask_q;
`else
  assign cmp_mask = '1;
`endif

  // cfg_load wins over din_valid, so a load cycle never consumes a data bit.
  assign accept      = din_valid & ~cfg_load;
  // Over-long lengths collapse to the full history width at latch time.
  assign len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;

  // Active configuration: defaults on reset, replaced wholesale by cfg_load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= DEFAULT_PATTERN;
      len_q  <= LEN_W'(DEFAULT_LEN);
      ovl_q  <= DEFAULT_OVERLAP;
`ifdef SEQ_DET_MASK_EN
      mask_q <= '1;
`endif
    end else if (cfg_load) begin
      pat_q  <= cfg_pattern;
      len_q  <= len_clamped;
      ovl_q  <= cfg_overlap;
`ifdef SEQ_DET_MASK_EN
      mask_q <= cfg_mask;
`endif
    end
  end

  // Match evaluation on the would-be history, so the pulse lands one clock
  // after the final pattern bit is sampled.
  always_comb begin
    len_mask  = '0;
    hist_next = {hist_q[MAX_LEN-2:0], din};
    fill_inc  = fill_q;
    match     = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    if (fill_q < len_q) begin
      fill_inc = fill_q + LEN_W'(1);
    end
    if (accept && (len_q != '0) && (fill_inc == len_q) &&
        (((hist_next ^ pat_q) & len_mask & cmp_mask) == '0)) begin
      match = 1'b1;
    end
  end

  // History, fill level, registered pulse and saturating count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (cfg_load) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      det_q <= match;
      if (accept) begin
        hist_q <= hist_next;
        // Non-overlap mode restarts the fill so the next hit needs fresh bits.
        fill_q <= (match && !ovl_q) ? '0 : fill_inc;
      end
      if (match && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign seq_detected = det_q;
  assign match_count  = cnt_q;
  assign fill_level   = fill_q;

endmodule
